// File: rtl/decryption_input_loader_pkg.sv
// rtl/decryption_input_loader_pkg.sv - shared state encodings and block width for the decryption input loader
package decryption_input_loader_pkg;

    localparam int AES_BLOCK_WIDTH = 128;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD_KEY  = 2'd1,
        LOAD_DATA = 2'd2
    } loader_state_t;

endpackage

// File: rtl/decryption_input_loader_word_assembler.sv
// rtl/decryption_input_loader_word_assembler.sv - staging shift register and word counter (word_assembler)
// Optional LOADER_BYTE_SWAP_EN reverses byte order within each incoming word.
module word_assembler
    import decryption_input_loader_pkg::*;
#(
    parameter int WORD_WIDTH = 32
) (
    input  logic                       clock,
    input  logic                       resetn,
    input  logic                       clear,
    input  logic                       shift,
    input  logic [WORD_WIDTH-1:0]      word,
    output logic                       done,
    output logic [AES_BLOCK_WIDTH-1:0] assembled
);

    localparam int N  = AES_BLOCK_WIDTH / WORD_WIDTH;
    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    logic [CW-1:0]                         count;
    logic [AES_BLOCK_WIDTH-WORD_WIDTH-1:0] staging;
    logic [WORD_WIDTH-1:0]                 word_ordered;

`ifdef LOADER_BYTE_SWAP_EN
    for (genvar b = 0; b < WORD_WIDTH / 8; b++) begin : g_swap
        assign word_ordered[b*8 +: 8] = word[WORD_WIDTH-8-b*8 +: 8];
    end
`else
    assign word_ordered = word;
`endif

    // The completed value is formed combinationally so the owner can capture it on the Nth edge.
    assign assembled = {staging, word_ordered};
    assign done      = shift && (count == LAST);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            count   <= '0;
            staging <= '0;
        end else if (clear) begin
            count   <= '0;
            staging <= '0;
        end else if (shift) begin
            staging <= assembled[AES_BLOCK_WIDTH-WORD_WIDTH-1:0];
            count   <= (count == LAST) ? '0 : count + CW'(1);
        end
    end

endmodule

// File: rtl/decryption_input_loader.sv
// rtl/decryption_input_loader.sv - key/ciphertext word loader FSM (optional LOADER_BYTE_SWAP_EN)
module decryption_input_loader
    import decryption_input_loader_pkg::*;
#(
    parameter int WORD_WIDTH = 32
) (
    input  logic                       clock,
    input  logic                       resetn,
    input  logic [WORD_WIDTH-1:0]      wordIn,
    input  logic                       wordValid,
    output logic                       wordReady,
    input  logic                       keyReload,
    output logic [AES_BLOCK_WIDTH-1:0] key,
    output logic [AES_BLOCK_WIDTH-1:0] inputData,
    output logic                       blockValid,
    output logic                       inputsLoadedFlag,
    output logic [15:0]                blockCount
);

    loader_state_t              state;
    logic                       transfer;
    logic                       done;
    logic [AES_BLOCK_WIDTH-1:0] assembled;

    // A word arriving on the same edge as keyReload is dropped.
    assign transfer = wordValid && wordReady && !keyReload;

    word_assembler #(.WORD_WIDTH(WORD_WIDTH)) u_word_assembler (
        .clock     (clock),
        .resetn    (resetn),
        .clear     (keyReload),
        .shift     (transfer),
        .word      (wordIn),
        .done      (done),
        .assembled (assembled)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state            <= IDLE;
            key              <= '0;
            inputData        <= '0;
            blockValid       <= 1'b0;
            inputsLoadedFlag <= 1'b0;
            blockCount       <= '0;
            wordReady        <= 1'b0;
        end else begin
            blockValid <= 1'b0;
            if (keyReload) begin
                state            <= LOAD_KEY;
                blockCount       <= '0;
                inputsLoadedFlag <= 1'b0;
                wordReady        <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        state     <= LOAD_KEY;
                        wordReady <= 1'b1;
                    end
                    LOAD_KEY: begin
                        if (done) begin
                            key   <= assembled;
                            state <= LOAD_DATA;
                        end
                    end
                    LOAD_DATA: begin
                        if (done) begin
                            inputData        <= assembled;
                            blockValid       <= 1'b1;
                            inputsLoadedFlag <= 1'b1;
                            blockCount       <= blockCount + 16'd1;
                        end
                    end
                    default: begin
                        state     <= IDLE;
                        wordReady <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_decryption_input_loader.sv
// tb/tb_decryption_input_loader.sv - directed scoreboard bench for decryption_input_loader (honours LOADER_BYTE_SWAP_EN)
module tb_decryption_input_loader;

    logic         clock = 1'b0;
    logic         resetn;
    logic [31:0]  wordIn;
    logic         wordValid;
    logic         wordReady;
    logic         keyReload;
    logic [127:0] key;
    logic [127:0] inputData;
    logic         blockValid;
    logic         inputsLoadedFlag;
    logic [15:0]  blockCount;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [127:0] data;
        logic [15:0]  count;
    } exp_t;
    exp_t sb[$];

    decryption_input_loader #(.WORD_WIDTH(32)) dut (
        .clock            (clock),
        .resetn           (resetn),
        .wordIn           (wordIn),
        .wordValid        (wordValid),
        .wordReady        (wordReady),
        .keyReload        (keyReload),
        .key              (key),
        .inputData        (inputData),
        .blockValid       (blockValid),
        .inputsLoadedFlag (inputsLoadedFlag),
        .blockCount       (blockCount)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] mw(input logic [31:0] w);
`ifdef LOADER_BYTE_SWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    function automatic logic [127:0] blk(input logic [31:0] a, b, c, d);
        return {mw(a), mw(b), mw(c), mw(d)};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [31:0] w);
        wordIn    = w;
        wordValid = 1'b1;
        step();
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 8 && wordReady !== 1'b1; i++) step();
        check("ready_after_reset", 128'(wordReady), 128'd1);
    endtask

    always @(negedge clock) begin
        if (resetn === 1'b1 && blockValid === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_block", 128'd1, 128'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_data", inputData, e.data);
                check("sb_count", 128'(blockCount), 128'(e.count));
            end
        end
    end

    initial begin
        logic [127:0] k1, k2, k3, d1, d_stall, d_new;
        logic [31:0]  w[12];

        resetn = 1'b0; wordIn = '0; wordValid = 1'b0; keyReload = 1'b0;
        #1;
        check("rst_ready", 128'(wordReady), 128'd0);
        check("rst_key", key, 128'd0);
        check("rst_data", inputData, 128'd0);
        check("rst_bv", 128'(blockValid), 128'd0);
        check("rst_flag", 128'(inputsLoadedFlag), 128'd0);
        check("rst_count", 128'(blockCount), 128'd0);
        step();
        resetn = 1'b1;
        wait_ready();

        // key load
        k1 = blk(32'h00010203, 32'h04050607, 32'h08090a0b, 32'h0c0d0e0f);
        send(32'h00010203); send(32'h04050607); send(32'h08090a0b); send(32'h0c0d0e0f);
        check("key1", key, k1);
        check("key1_bv", 128'(blockValid), 128'd0);
        check("key1_flag", 128'(inputsLoadedFlag), 128'd0);

        // first data block
        d1 = blk(32'h69c4e0d8, 32'h6a7b0430, 32'hd8cdb780, 32'h70b4c55a);
        sb.push_back('{d1, 16'd1});
        send(32'h69c4e0d8); send(32'h6a7b0430); send(32'hd8cdb780); send(32'h70b4c55a);
        wordValid = 1'b0;
        check("blk1_data", inputData, d1);
        check("blk1_bv", 128'(blockValid), 128'd1);
        check("blk1_flag", 128'(inputsLoadedFlag), 128'd1);
        check("blk1_count", 128'(blockCount), 128'd1);
        step();
        check("blk1_bv_once", 128'(blockValid), 128'd0);

        // fresh key then 12 back-to-back words
        keyReload = 1'b1; step(); keyReload = 1'b0;
        k2 = blk(32'hdeadbeef, 32'h01234567, 32'h89abcdef, 32'hcafef00d);
        send(32'hdeadbeef); send(32'h01234567); send(32'h89abcdef); send(32'hcafef00d);
        check("key2", key, k2);
        for (int i = 0; i < 12; i++) w[i] = $urandom;
        for (int b = 0; b < 3; b++)
            sb.push_back('{blk(w[4*b], w[4*b+1], w[4*b+2], w[4*b+3]), 16'(b + 1)});
        for (int i = 0; i < 12; i++) begin
            send(w[i]);
            check($sformatf("b2b_bv_%0d", i + 1), 128'(blockValid), 128'((i % 4) == 3));
        end
        check("b2b_count", 128'(blockCount), 128'd3);
        wordValid = 1'b0;

        // stalled assembly
        d_stall = blk(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);
        sb.push_back('{d_stall, 16'd4});
        send(32'h11111111); send(32'h22222222);
        wordValid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("stall_data_held", inputData, blk(w[8], w[9], w[10], w[11]));
        end
        send(32'h33333333); send(32'h44444444);
        wordValid = 1'b0;
        check("stall_data", inputData, d_stall);
        check("stall_count", 128'(blockCount), 128'd4);

        // mid-block reload, word on the reload edge discarded, reload held two cycles
        send(32'h55555555); send(32'h66666666);
        wordIn = 32'hbadbadba; wordValid = 1'b1; keyReload = 1'b1;
        step();
        check("rl_flag", 128'(inputsLoadedFlag), 128'd0);
        check("rl_count", 128'(blockCount), 128'd0);
        check("rl_key_held", key, k2);
        check("rl_data_held", inputData, d_stall);
        step();
        keyReload = 1'b0;
        k3 = blk(32'ha0a1a2a3, 32'hb0b1b2b3, 32'hc0c1c2c3, 32'hd0d1d2d3);
        send(32'ha0a1a2a3); send(32'hb0b1b2b3); send(32'hc0c1c2c3);
        check("rl_key_partial", key, k2);
        send(32'hd0d1d2d3);
        check("rl_key_new", key, k3);
        d_new = blk(32'h0f0e0d0c, 32'h0b0a0908, 32'h07060504, 32'h03020100);
        sb.push_back('{d_new, 16'd1});
        send(32'h0f0e0d0c); send(32'h0b0a0908); send(32'h07060504); send(32'h03020100);
        wordValid = 1'b0;
        check("rl_blk_data", inputData, d_new);
        check("rl_blk_count", 128'(blockCount), 128'd1);

        // reset mid-assembly
        send(32'h77777777); send(32'h88888888);
        wordValid = 1'b0;
        resetn = 1'b0;
        #1;
        check("mrst_key", key, 128'd0);
        check("mrst_data", inputData, 128'd0);
        check("mrst_ready", 128'(wordReady), 128'd0);
        check("mrst_count", 128'(blockCount), 128'd0);
        step();
        resetn = 1'b1;
        wait_ready();
        send(32'h03020100); send(32'h07060504); send(32'h0b0a0908); send(32'h0f0e0d0c);
        wordValid = 1'b0;
        check("mrst_key_new", key, blk(32'h03020100, 32'h07060504, 32'h0b0a0908, 32'h0f0e0d0c));
        step();
        step();
        check("sb_empty", 128'(sb.size()), 128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/decryption_input_loader.md
DECRYPTION_INPUT_LOADER -- requirements
Module: decryption_input_loader

Interface
REQ-001 Parameter WORD_WIDTH, default 32, SHALL be the width of one input word; legal values are 8, 32 and 64.
REQ-002 clock  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 resetn  input  1  SHALL be an asynchronous, active-low reset.
REQ-004 wordIn  input  WORD_WIDTH  SHALL carry one key or ciphertext word.
REQ-005 wordValid  input  1  SHALL mark wordIn as valid.
REQ-006 wordReady  output  1  SHALL indicate the loader accepts a word this cycle.
REQ-007 keyReload  input  1  SHALL request a new key load; level-sampled each cycle.
REQ-008 key  output  128  SHALL carry the last fully assembled key.
REQ-009 inputData  output  128  SHALL carry the last fully assembled ciphertext block.
REQ-010 blockValid  output  1  SHALL be a one-cycle pulse marking a new inputData value.
REQ-011 inputsLoadedFlag  output  1  SHALL be high once a key and at least one data block are loaded.
REQ-012 blockCount  output  16  SHALL count completed data blocks since the last key load.

Function
REQ-013 Transfer SHALL occur on a rising edge with wordValid=1 and wordReady=1.
REQ-014 States SHALL be IDLE, LOAD_KEY and LOAD_DATA: IDLE goes to LOAD_KEY unconditionally, LOAD_KEY goes to LOAD_DATA after the last key word, and LOAD_DATA stays in LOAD_DATA.
REQ-015 wordReady SHALL be 0 in IDLE and 1 in LOAD_KEY and LOAD_DATA, with no backpressure, because the downstream pipeline accepts one block per cycle.
REQ-016 N = 128/WORD_WIDTH words SHALL form one 128-bit value, and the first word transferred SHALL occupy the most-significant bits.
REQ-017 Words SHALL assemble in a staging register, and key/inputData SHALL update atomically on the edge that transfers the Nth word; partial values are never visible.
REQ-018 blockValid SHALL be 1 in exactly the cycle following that edge, coincident with the new inputData value.
REQ-019 In LOAD_DATA the word counter SHALL wrap from N-1 to 0, allowing back-to-back blocks with no bubble; at WORD_WIDTH=32 continuous valid yields one blockValid every 4 cycles.
REQ-020 inputsLoadedFlag SHALL set with the first blockValid after a key load and stay set until reset or keyReload.
REQ-021 blockCount SHALL increment with each blockValid and wrap from 16'hFFFF to 0.
REQ-022 keyReload=1 in any state SHALL, on the next edge, move the block to LOAD_KEY and take these actions:
- clear the word counter, staging register, blockCount and inputsLoadedFlag;
- discard any word transferred on that same edge;
- keep key and inputData holding their old values until a new key/block completes.
REQ-023 keyReload held high SHALL keep the block in LOAD_KEY with the word counter at 0.
REQ-024 wordValid=0 mid-assembly SHALL stall assembly without losing already accepted words.

Reset
REQ-025 resetn=0 SHALL immediately force the following:
- state=IDLE and word counter=0;
- key=0, inputData=0 and staging register=0;
- blockValid=0, inputsLoadedFlag=0, blockCount=0 and wordReady=0.
REQ-026 Reset asserted mid-assembly SHALL discard the partial value, and after release the first transferred word SHALL be treated as key word 0.

Configuration
REQ-027 Macro LOADER_BYTE_SWAP_EN, when defined, SHALL reverse byte order within each wordIn before assembly.
REQ-028 Without LOADER_BYTE_SWAP_EN, words SHALL be used unmodified; the macro SHALL have no effect when WORD_WIDTH=8.

Structure
REQ-029 A shared package SHALL hold:
- the state encodings (IDLE=0, LOAD_KEY=1, LOAD_DATA=2);
- the AES block width constant (128).
REQ-030 One sub-module, word_assembler, SHALL contain the staging shift register and word counter, reporting completion to the loader FSM.

Verification
REQ-031 Key load SHALL be checked: release reset, send 32-bit words 00010203, 04050607, 08090a0b, 0c0d0e0f -> key=000102030405060708090a0b0c0d0e0f, blockValid=0, inputsLoadedFlag=0.
REQ-032 First data block SHALL be checked: send 69c4e0d8, 6a7b0430, d8cdb780, 70b4c55a -> inputData=69c4e0d86a7b0430d8cdb78070b4c55a, blockValid pulses once, inputsLoadedFlag=1, blockCount=1.
REQ-033 Back-to-back blocks SHALL be checked: 12 consecutive valid words -> blockValid at cycles 4, 8 and 12 after start, with blockCount=3.
REQ-034 Stalled assembly SHALL be checked: wordValid dropped for 5 cycles after 2 data words -> inputData unchanged, and the block completes correctly after 2 more words.
REQ-035 Mid-block key reload SHALL be checked: keyReload after 2 data words -> inputsLoadedFlag=0, blockCount=0, old key held, and the next 4 words form a new key.
REQ-036 Byte swap SHALL be checked with LOADER_BYTE_SWAP_EN defined: word 03020100 first -> key[127:96]=00010203.
